// File: rtl/div16_by8_r4_seq_pkg.sv
// div_pkg: shared constants and FSM state type for the radix-4 sequential divider
package div_pkg;
  localparam int N = 8;
  localparam int N_ITER = N;
  localparam int CNT_W = $clog2(N_ITER);
  localparam int PR_W = N + 2;
  localparam logic [2*N-1:0] DZ_Q = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div16_by8_r4_seq_if.sv
// div16_by8_r4_seq_if: operand/result valid-ready bundle for the divider
// master drives in_valid/A/B/out_ready; slave (the divider) drives in_ready/out_valid/Q/R[/dz_err].
// dz_err exists only when DIV_ZERO_ERR_EN is defined.
interface div16_by8_r4_seq_if;
  import div_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [2*N-1:0] A;
  logic [N-1:0] B;
  logic out_valid;
  logic out_ready;
  logic [2*N-1:0] Q;
  logic [N-1:0] R;
`ifdef DIV_ZERO_ERR_EN
  logic dz_err;
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Q, R, dz_err);
  modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, Q, R, dz_err);
`else
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Q, R);
  modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, Q, R);
`endif
endinterface

// File: rtl/div16_by8_r4_seq_step.sv
// div_r4_step: one radix-4 restoring step, shifts two dividend bits into pr and subtracts the largest k*B
// pr_i: partial remainder, d_i: next two dividend bits, b_i: divisor; q_o: digit, pr_o: next partial remainder
module div_r4_step
  import div_pkg::*;
(
  input  logic [PR_W-1:0] pr_i,
  input  logic [1:0]      d_i,
  input  logic [N-1:0]    b_i,
  output logic [1:0]      q_o,
  output logic [PR_W-1:0] pr_o
);
  logic [PR_W-1:0] sh, b1, b2, b3;
  assign sh = (pr_i << 2) | {{(PR_W-2){1'b0}}, d_i};
  assign b1 = {2'b00, b_i};
  assign b2 = {1'b0, b_i, 1'b0};
  assign b3 = b1 + b2;
  assign q_o = sh >= b3 ? 2'd3 : sh >= b2 ? 2'd2 : sh >= b1 ? 2'd1 : 2'd0;
  assign pr_o = sh - (q_o == 2'd3 ? b3 : q_o == 2'd2 ? b2 : q_o == 2'd1 ? b1 : '0);
endmodule

// File: rtl/div16_by8_r4_seq.sv
// div16_by8_r4_seq: sequential 16/8 unsigned divider, radix-4 restoring, 2 quotient bits per cycle
// clk/rst: clock and async active-high reset; io: div16_by8_r4_seq_if slave (A/B in, Q/R out, valid/ready both sides).
// DIV_ZERO_ERR_EN adds the dz_err flag; a zero divisor always yields Q=FFFF, R=A[7:0].
module div16_by8_r4_seq
  import div_pkg::*;
(
  input logic clk,
  input logic rst,
  div16_by8_r4_seq_if.slave io
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] qs_q, qs_d, q_q, q_d;
  logic [N-1:0] b_q, b_d, r_q, r_d;
  logic [PR_W-1:0] pr_q, pr_d, pr_n;
  logic [1:0] dig;
  logic ov_q, ov_d;
  div_r4_step u_step (.pr_i(pr_q), .d_i(qs_q[2*N-1:2*N-2]), .b_i(b_q), .q_o(dig), .pr_o(pr_n));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    qs_d = qs_q;
    b_d = b_q;
    pr_d = pr_q;
    q_d = q_q;
    r_d = r_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        qs_d = io.A;
        b_d = io.B;
        pr_d = '0;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        qs_d = {qs_q[2*N-3:0], dig};
        pr_d = pr_n;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(N_ITER - 1) ? DONE : RUN;
      end
      DONE: if (!ov_q) begin
        // with B=0 every digit is 3 and pr just accumulates the low dividend bits, so pr[7:0]=A[7:0]
        ov_d = 1'b1;
        q_d = b_q == '0 ? DZ_Q : qs_q;
        r_d = pr_q[N-1:0];
      end else if (io.out_ready) begin
        ov_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      qs_q <= '0;
      b_q <= '0;
      pr_q <= '0;
      q_q <= '0;
      r_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      qs_q <= qs_d;
      b_q <= b_d;
      pr_q <= pr_d;
      q_q <= q_d;
      r_q <= r_d;
      ov_q <= ov_d;
    end
  assign io.in_ready = state_q == IDLE;
  assign io.out_valid = ov_q;
  assign io.Q = q_q;
  assign io.R = r_q;
`ifdef DIV_ZERO_ERR_EN
  logic dz_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) dz_q <= 1'b0;
    else if (state_q == DONE && !ov_q) dz_q <= b_q == '0;
    else if (ov_q && io.out_ready) dz_q <= 1'b0;
  assign io.dz_err = dz_q;
`endif
endmodule

// File: tb/tb_div16_by8_r4_seq.sv
// tb_div16_by8_r4_seq: directed self-checking bench for the radix-4 sequential divider
module tb_div16_by8_r4_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0;
  int nerr = 0;
  div16_by8_r4_seq_if io();
  div16_by8_r4_seq dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq, input logic [7:0] er, input int hold);
    int n;
    io.A = a;
    io.B = b;
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk("busy_after_accept", io.in_ready, 0);
    n = 0;
    while (!io.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    chk("Q", io.Q, eq);
    chk("R", io.R, er);
`ifdef DIV_ZERO_ERR_EN
    chk("dz_err", io.dz_err, b == 8'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      io.in_valid = 1'b1;
      io.A = ~a;
      io.B = b + 8'd1;
      @(posedge clk); #1;
      chk("hold_Q", io.Q, eq);
      chk("hold_R", io.R, er);
      chk("hold_valid", io.out_valid, 1);
      chk("hold_ready", io.in_ready, 0);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    chk("drained", io.out_valid, 0);
    chk("ready_again", io.in_ready, 1);
`ifdef DIV_ZERO_ERR_EN
    chk("dz_cleared", io.dz_err, 0);
`endif
  endtask
  initial begin
    logic [15:0] ra;
    logic [7:0] rb;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.A = '0;
    io.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_Q", io.Q, 0);
    chk("rst_R", io.R, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 0);
    op(16'd1000, 8'd7, 16'd142, 8'd6, 0);
    op(16'd0, 8'd5, 16'd0, 8'd0, 0);
    op(16'h00FF, 8'd1, 16'h00FF, 8'h00, 0);
    op(16'hFFFF, 8'd1, 16'hFFFF, 8'h00, 0);
    op(16'd100, 8'd200, 16'd0, 8'd100, 0);
    op(16'hFFFF, 8'd2, 16'h7FFF, 8'h01, 0);
    op(16'hABCD, 8'h10, 16'h0ABC, 8'h0D, 0);
    op(16'hFFFF, 8'h80, 16'h01FF, 8'h7F, 0);
    op(16'h1234, 8'd0, 16'hFFFF, 8'h34, 0);
    op(16'h8000, 8'd3, 16'h2AAA, 8'h02, 20);
    repeat (3) begin
      @(posedge clk); #1;
      chk("single_drain", io.out_valid, 0);
    end
    io.A = 16'hFFFF;
    io.B = 8'h0F;
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", io.in_ready, 1);
    chk("async_rst_out_valid", io.out_valid, 0);
    chk("async_rst_Q", io.Q, 0);
    chk("async_rst_R", io.R, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("discarded", io.out_valid, 0);
    end
    op(16'd5000, 8'd13, 16'd384, 8'd8, 2);
    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(1, 255));
      op(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
